chunked_seq_adder: RTL

- Parametrised multi-cycle adder/subtractor and the next generation of the team's 4-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock through a small ripple chain, carrying between cycles in a register.
- Uses valid/ready handshakes on input and output, so the ALU datapath can trade latency for area at wide widths.
- Adds a subtract mode and a signed-overflow flag.

---
 rtl/chunked_seq_adder_pkg.sv | 24 ++
 rtl/full_adder.sv | 15 +
 rtl/ripple_adder_n.sv | 36 +++
 rtl/chunked_seq_adder.sv | 117 +++++++++++
 4 files changed

// File: rtl/chunked_seq_adder_pkg.sv
// rtl/chunked_seq_adder_pkg.sv - shared FSM encoding and sizing helpers for chunked_seq_adder
// Purpose: state encoding for the IDLE/BUSY/DONE controller and the chunk-count
//          and counter-width helpers shared by the top and the bench.
// Ports:   none (package).
package chunked_seq_adder_pkg;

    // 2'd3 is unreachable in normal operation; the FSM maps it back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_BAD  = 2'd3
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit counter to stay legal.
    function automatic int calc_cnt_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell
// Purpose: single-bit sum/carry cell used to build ripple chains.
// Ports:   a, b, cin -> s, cout.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_adder_n.sv
// rtl/ripple_adder_n.sv - N-bit combinational ripple adder built from full_adder cells
// Purpose: adds one chunk per cycle for chunked_seq_adder.
// Ports:   a[N], b[N], cin -> s[N], cout (carry out of top bit),
//          cmsb (carry into top bit, used for signed overflow).
module ripple_adder_n #(
    parameter int N = 2
) (
    output logic [N-1:0] s,
    output logic         cout,
    output logic         cmsb,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin
);

    logic [N:0] w_c;

    assign w_c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_fa
            full_adder u_fa (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (w_c[i]),
                .s    (s[i]),
                .cout (w_c[i+1])
            );
        end
    endgenerate

    assign cout = w_c[N];
    assign cmsb = w_c[N-1];

endmodule

// File: rtl/chunked_seq_adder.sv
// rtl/chunked_seq_adder.sv - multi-cycle chunked adder/subtractor with valid/ready handshakes
// Purpose: computes a+b+cin or a-b-cin over WIDTH bits, CHUNK bits per cycle,
//          keeping the inter-chunk carry in a register.
// Ports:   clk, rst (async, active-high)
//          in_valid/in_ready, a, b, cin, sub : operand handshake (accept in IDLE only)
//          out_valid/out_ready, s, cout, ovf : result handshake (valid in DONE only)
module chunked_seq_adder
    import chunked_seq_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int CW     = calc_cnt_w(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_sum;
    logic             w_chunk_cout;
    logic             w_chunk_cmsb;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign s         = r_s;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    assign w_accept  = in_valid && (r_state == ST_IDLE);
    assign w_last    = (r_cnt == LAST);
    assign w_a_chunk = r_a[int'(r_cnt)*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[int'(r_cnt)*CHUNK +: CHUNK];

    ripple_adder_n #(.N(CHUNK)) u_ripple (
        .s    (w_sum),
        .cout (w_chunk_cout),
        .cmsb (w_chunk_cmsb),
        .a    (w_a_chunk),
        .b    (w_b_chunk),
        .cin  (r_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_next = ST_BUSY;
            ST_BUSY: if (w_last)    w_next = ST_DONE;
            ST_DONE: if (out_ready) w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
    end

    // Subtraction is a + ~b + ~cin: B is inverted once at capture so the
    // chunk datapath is a plain adder for both modes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? ~cin : cin;
            r_cnt   <= '0;
            r_s     <= '0;
        end else if (r_state == ST_BUSY) begin
            r_s[int'(r_cnt)*CHUNK +: CHUNK] <= w_sum;
            r_carry <= w_chunk_cout;
            if (w_last) begin
                r_cout <= w_chunk_cout;
                r_ovf  <= w_chunk_cmsb ^ w_chunk_cout;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
